// File: rtl/data_memory_master.sv
// Initiator for the data-memory port: single outstanding load/store with programmable
// wait latency, one-cycle memory strobe, valid/ready response and saturating access counters.
module data_memory_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic [CNT_WIDTH-1:0]  o_rd_count,
  output logic [CNT_WIDTH-1:0]  o_wr_count
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                r_state, w_state_d;
  logic                  r_we, w_we_d;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx_d;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
  logic [7:0]            r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
  logic                  r_err, w_err_d;
  logic [CNT_WIDTH-1:0]  r_rd_count, w_rd_count_d;
  logic [CNT_WIDTH-1:0]  r_wr_count, w_wr_count_d;

  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_bad_addr;
  logic                  w_strobe;

  assign w_word_idx = {2'b00, i_req_addr[ADDR_WIDTH-1:2]};
  assign w_bad_addr = (i_req_addr[1:0] != 2'b00) || (w_word_idx >= ADDR_WIDTH'(RAM_DEPTH));
  assign w_strobe   = (r_state == StWait) && (r_cnt == 8'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_we       <= w_we_d;
      r_idx      <= w_idx_d;
      r_wdata    <= w_wdata_d;
      r_cnt      <= w_cnt_d;
      r_rdata    <= w_rdata_d;
      r_err      <= w_err_d;
      r_rd_count <= w_rd_count_d;
      r_wr_count <= w_wr_count_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_we_d       = r_we;
    w_idx_d      = r_idx;
    w_wdata_d    = r_wdata;
    w_cnt_d      = r_cnt;
    w_rdata_d    = r_rdata;
    w_err_d      = r_err;
    w_rd_count_d = r_rd_count;
    w_wr_count_d = r_wr_count;

    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_we_d    = i_req_we;
          w_idx_d   = w_word_idx;
          w_wdata_d = i_req_wdata;
          if (w_bad_addr) begin
            w_err_d   = 1'b1;
            w_rdata_d = '0;
            w_state_d = StResp;
          end else begin
            w_cnt_d   = 8'(LATENCY - 1);
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (r_cnt != 8'd0) begin
          w_cnt_d = r_cnt - 8'd1;
        end else begin
          // Strobe cycle: the memory read data is combinational, so capture it here.
          w_rdata_d = r_we ? '0 : i_mem_rd_data;
          w_err_d   = 1'b0;
          w_state_d = StResp;
          if (r_we) begin
            if (r_wr_count != {CNT_WIDTH{1'b1}}) w_wr_count_d = r_wr_count + CNT_WIDTH'(1);
          end else begin
            if (r_rd_count != {CNT_WIDTH{1'b1}}) w_rd_count_d = r_rd_count + CNT_WIDTH'(1);
          end
        end
      end
      StResp: begin
        if (i_rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready   = (r_state == StIdle);
    o_busy        = (r_state != StIdle);
    o_rsp_valid   = (r_state == StResp);
    o_rsp_rdata   = r_rdata;
    o_rsp_err     = r_err;
    o_mem_wr_en   = w_strobe && r_we;
    o_mem_rd_en   = w_strobe && !r_we;
    o_mem_addr    = (r_state == StWait) ? r_idx : '0;
    o_mem_wr_data = (r_state == StWait) ? r_wdata : '0;
    o_rd_count    = r_rd_count;
    o_wr_count    = r_wr_count;
  end

endmodule

// File: tb/tb_data_memory_master.sv
// Randomized self-checking bench for data_memory_master against a transaction-level model
// of the memory contents, response latency and saturating counters.
module tb_data_memory_master;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LAT     = 2;
  localparam int unsigned CW      = 2;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic [CW-1:0] rd_count, wr_count;

  // Memory attached to the DUT, plus a preload port used during reset.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          fill_en;
  logic [7:0]    fill_idx;
  logic [DW-1:0] fill_data;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (fill_en) mem[fill_idx] <= fill_data;
    else if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;
  end

  data_memory_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (DEPTH),
    .LATENCY   (LAT),
    .CNT_WIDTH (CW)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_busy       (busy),
    .o_mem_wr_en  (mem_wr_en),
    .o_mem_rd_en  (mem_rd_en),
    .o_mem_addr   (mem_addr),
    .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_rd_data),
    .o_rd_count   (rd_count),
    .o_wr_count   (wr_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 32'({rsp_valid, rsp_err, busy, mem_wr_en, mem_rd_en, req_ready}),
             32'h1);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_mem_bus"}, mem_addr | mem_wr_data, 32'h0);
    check_eq({tag, "_counts"}, 32'({rd_count, wr_count}), 32'h0);
  endtask

  // One complete transaction; called at a falling edge with the DUT idle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold);
    logic [31:0] widx, exp_data, strobe_addr;
    logic        err;
    int          n, rd_seen, wr_seen, strobe_at, viol;
    widx     = addr >> 2;
    err      = (addr[1:0] != 2'b00) || (widx >= DEPTH);
    exp_data = (err || we) ? 32'h0 : ref_mem[widx[7:0]];
    if (!err) begin
      if (we) begin
        ref_mem[widx[7:0]] = wdata;
        if (exp_wr < CNT_MAX) exp_wr++;
      end else if (exp_rd < CNT_MAX) begin
        exp_rd++;
      end
    end

    check_eq("req_ready_before", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    n = 0; rd_seen = 0; wr_seen = 0; strobe_at = -1; strobe_addr = '0; viol = 0;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    while (!rsp_valid && n < 20) begin
      if (req_ready || !busy) viol++;
      if (mem_rd_en && mem_wr_en) viol++;
      if (mem_rd_en) begin rd_seen++; strobe_at = n; strobe_addr = mem_addr; end
      if (mem_wr_en) begin wr_seen++; strobe_at = n; strobe_addr = mem_addr; end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq("rsp_latency", n, err ? 32'h0 : LAT);
    check_eq("rd_strobes", rd_seen, (!err && !we) ? 32'h1 : 32'h0);
    check_eq("wr_strobes", wr_seen, (!err && we) ? 32'h1 : 32'h0);
    if (!err) begin
      check_eq("strobe_cycle", strobe_at, LAT - 1);
      check_eq("strobe_addr", strobe_addr, widx);
    end
    check_eq("rsp_err", 32'(rsp_err), 32'(err));
    check_eq("rsp_rdata", rsp_rdata, exp_data);

    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || !busy || req_ready) viol++;
      if (rsp_rdata !== exp_data || rsp_err !== err) viol++;
      if (mem_rd_en || mem_wr_en) viol++;
    end
    check_eq("protocol_violations", viol, 32'h0);

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("back_to_idle", 32'({rsp_valid, busy, mem_rd_en, mem_wr_en, req_ready}), 32'h1);
    check_eq("idle_mem_addr", mem_addr, 32'h0);
    check_eq("rd_count", 32'(rd_count), exp_rd);
    check_eq("wr_count", 32'(wr_count), exp_wr);
  endtask

  initial begin
    int diffs;
    logic [31:0] a;
    int r;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; fill_en = 1'b0; fill_idx = '0; fill_data = '0;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      fill_en   = 1'b1;
      fill_idx  = 8'(i);
      fill_data = (i == 5) ? 32'hFFFF_FFFA : $urandom;
      ref_mem[i] = fill_data;
    end
    @(negedge clk);
    fill_en = 1'b0;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    access(1'b0, 32'h14, 32'h0, 0);
    access(1'b1, 32'h3FC, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h3FC, 32'h0, 1);
    access(1'b0, 32'h401, 32'h0, 0);
    access(1'b1, 32'h400, 32'h1234_5678, 0);
    access(1'b0, 32'h20, 32'h0, 5);

    // Reset asserted between edges while the store strobe is pending.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = ~ref_mem[4];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    check_eq("aborted_store_mem4", mem[4], ref_mem[4]);
    @(negedge clk);

    repeat (5) access(1'b0, {22'h0, 8'($urandom), 2'b00}, 32'h0, 0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = {22'h0, 8'($urandom), 2'b00};
      else if (r == 7) a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
      else             a = {20'h0, 10'($urandom_range(256, 1023)), 2'b00};
      access(1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check_eq("final_memory_diffs", diffs, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
